// File: rtl/drum_midi_tx_if.sv
// Pad-trigger and MIDI-line bundle for drum_midi_tx.
// The master side fires pads; the slave side drives the UART line.
interface drum_midi_tx_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          trig_cymbal;
  logic          trig_hihat;
  logic          trig_tom;
  logic          trig_snare;
  logic          trig_kick;
  logic          midi_tx;
  logic          busy;
  logic          overflow;
  logic [LW-1:0] fifo_level;

  modport master (
    output trig_cymbal,
    output trig_hihat,
    output trig_tom,
    output trig_snare,
    output trig_kick,
    input  midi_tx,
    input  busy,
    input  overflow,
    input  fifo_level
  );

  modport slave (
    input  trig_cymbal,
    input  trig_hihat,
    input  trig_tom,
    input  trig_snare,
    input  trig_kick,
    output midi_tx,
    output busy,
    output overflow,
    output fifo_level
  );
endinterface

// File: rtl/drum_midi_tx.sv
// Drum pad hits -> MIDI Note-On over 8N1 UART.
// Pending coalescer feeds a note FIFO drained by a byte serializer.
module drum_midi_tx #(
  parameter int CLK_FREQ       = 48000000,
  parameter int BAUD           = 31250,
  parameter int FIFO_DEPTH     = 8,
  parameter int MIDI_CH        = 9,
  parameter int VELOCITY       = 100,
  parameter int RUNNING_STATUS = 1
) (
  input logic           clk,
  input logic           rst_n,
  drum_midi_tx_if.slave pad_if
);
  localparam int BIT_DIV = CLK_FREQ / BAUD;
  localparam int CW      = $clog2(BIT_DIV);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;

  localparam logic [7:0]    STATUS = 8'h90 | 8'(MIDI_CH & 15);
  localparam logic [7:0]    VEL    = 8'(VELOCITY);
  localparam logic [CW-1:0] LAST   = CW'(BIT_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_e;

  logic [4:0]    trig;
  logic [4:0]    pend_q, pend_d;
  logic [4:0]    sel, clr;
  logic [6:0]    sel_note;
  logic          ovf_q, ovf_d;
  logic          push, pop;
  logic          full, empty;
  logic [LW-1:0] wp_q, rp_q, level;
  logic [6:0]    mem [FIFO_DEPTH];

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    bsel_q, bsel_d;
  logic [6:0]    note_q, note_d;
  logic          lsv_q, lsv_d;
  logic          tx_q, tx_d;
  logic          tick;
  logic [7:0]    cur;

  assign trig = {pad_if.trig_cymbal,
                 pad_if.trig_hihat,
                 pad_if.trig_tom,
                 pad_if.trig_snare,
                 pad_if.trig_kick};

  always_comb begin
    sel      = '0;
    sel_note = 7'h00;
    if (pend_q[4]) begin
      sel      = 5'b10000;
      sel_note = 7'h31;
    end else if (pend_q[3]) begin
      sel      = 5'b01000;
      sel_note = 7'h2A;
    end else if (pend_q[2]) begin
      sel      = 5'b00100;
      sel_note = 7'h2D;
    end else if (pend_q[1]) begin
      sel      = 5'b00010;
      sel_note = 7'h26;
    end else if (pend_q[0]) begin
      sel      = 5'b00001;
      sel_note = 7'h24;
    end
  end

  assign level = wp_q - rp_q;
  assign full  = level == LW'(FIFO_DEPTH);
  assign empty = level == '0;
  assign push  = (pend_q != '0) && !full;
  assign clr   = push ? sel : '0;

  // A bit being pushed this cycle may be re-armed without loss.
  assign pend_d = (pend_q & ~clr) | trig;
  assign ovf_d  = |(trig & pend_q & ~clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
      wp_q   <= '0;
      rp_q   <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      if (push) wp_q <= wp_q + LW'(1);
      if (pop)  rp_q <= rp_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp_q[AW-1:0]] <= sel_note;
  end

  assign tick = cnt_q == LAST;

  always_comb begin
    unique case (bsel_q)
      2'd0:    cur = STATUS;
      2'd1:    cur = {1'b0, note_q};
      default: cur = VEL;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    bsel_d  = bsel_q;
    note_d  = note_q;
    lsv_d   = lsv_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          note_d  = mem[rp_q[AW-1:0]];
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = START;
        cnt_d   = '0;
        bsel_d  = (RUNNING_STATUS != 0 && lsv_q) ? 2'd1 : 2'd0;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (bsel_q == 2'd0) lsv_d = 1'b1;
          if (bsel_q == 2'd2) begin
            state_d = IDLE;
          end else begin
            bsel_d  = bsel_q + 2'd1;
            state_d = START;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the state being entered, keeping midi_tx a flop.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      bsel_q  <= '0;
      note_q  <= '0;
      lsv_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      bsel_q  <= bsel_d;
      note_q  <= note_d;
      lsv_q   <= lsv_d;
      tx_q    <= tx_d;
    end
  end

  assign pad_if.midi_tx    = tx_q;
  assign pad_if.overflow   = ovf_q;
  assign pad_if.fifo_level = level;
  assign pad_if.busy       = (state_q != IDLE)
                           | (level != '0)
                           | (pend_q != '0);
endmodule

// File: tb/tb_drum_midi_tx.sv
// Scoreboard bench for drum_midi_tx: one running-status DUT, one without.
// UART receivers decode both lines and compare against queued bytes.
module tb_drum_midi_tx;
  localparam int CLK_FREQ = 500000;
  localparam int BAUD     = 31250;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic clk;
  logic rst_n;
  logic [1:0] ln;

  int checks = 0;
  int errors = 0;
  int ovf0 = 0;
  int ovf1 = 0;
  bit st0 = 0;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic [7:0] notes [5] = '{8'h24, 8'h26, 8'h2D, 8'h2A, 8'h31};

  drum_midi_tx_if #(.FIFO_DEPTH(8)) if0 ();
  drum_midi_tx_if #(.FIFO_DEPTH(8)) if1 ();

  drum_midi_tx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(8),
    .MIDI_CH(9), .VELOCITY(100), .RUNNING_STATUS(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .pad_if(if0)
  );

  drum_midi_tx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(8),
    .MIDI_CH(9), .VELOCITY(100), .RUNNING_STATUS(0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .pad_if(if1)
  );

  assign ln = {if1.midi_tx, if0.midi_tx};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if0.overflow) ovf0++;
    if (if1.overflow) ovf1++;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic set_trig(input logic [4:0] m);
    if0.trig_cymbal = m[4]; if1.trig_cymbal = m[4];
    if0.trig_hihat  = m[3]; if1.trig_hihat  = m[3];
    if0.trig_tom    = m[2]; if1.trig_tom    = m[2];
    if0.trig_snare  = m[1]; if1.trig_snare  = m[1];
    if0.trig_kick   = m[0]; if1.trig_kick   = m[0];
  endtask

  task automatic push_msg(input logic [7:0] n);
    if (!st0) begin
      exp0.push_back(8'h99);
      st0 = 1'b1;
    end
    exp0.push_back(n);
    exp0.push_back(8'h64);
    exp1.push_back(8'h99);
    exp1.push_back(n);
    exp1.push_back(8'h64);
  endtask

  task automatic hit(input logic [4:0] m, input bit expect_msg);
    set_trig(m);
    if (expect_msg)
      for (int i = 4; i >= 0; i--)
        if (m[i]) push_msg(notes[i]);
    @(negedge clk);
    set_trig(5'b0);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((if0.busy || if1.busy || exp0.size() != 0 ||
            exp1.size() != 0) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " drain"}, 32'(n < 8000), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic rx(input int k, output logic [7:0] b,
                    output bit ok, output bit glitch);
    logic v;
    b = '0;
    ok = 1'b1;
    glitch = 1'b0;
    for (int i = 0; i < 10; i++) begin
      v = ln[k];
      for (int c = 1; c < DIV; c++) begin
        @(negedge clk);
        if (!rst_n) begin
          ok = 1'b0;
          return;
        end
        if (ln[k] !== v) glitch = 1'b1;
      end
      if (i == 0 && v !== 1'b0) glitch = 1'b1;
      if (i == 9 && v !== 1'b1) glitch = 1'b1;
      if (i >= 1 && i <= 8) b[i-1] = v;
      if (i < 9) begin
        @(negedge clk);
        if (!rst_n) begin
          ok = 1'b0;
          return;
        end
      end
    end
  endtask

  task automatic mon(input int k);
    logic [7:0] b, e;
    bit ok, glitch, none;
    forever begin
      @(negedge clk);
      if (rst_n && ln[k] == 1'b0) begin
        rx(k, b, ok, glitch);
        if (ok) begin
          checks++;
          if (glitch) begin
            errors++;
            $display("FAIL rx%0d frame: bad bit timing in byte %02h",
                     k, b);
          end
          checks++;
          none = (k == 0) ? (exp0.size() == 0) : (exp1.size() == 0);
          if (none) begin
            errors++;
            $display("FAIL rx%0d byte: got %02h expected none", k, b);
          end else begin
            if (k == 0) e = exp0.pop_front();
            else        e = exp1.pop_front();
            if (b !== e) begin
              errors++;
              $display("FAIL rx%0d byte: got %02h expected %02h",
                       k, b, e);
            end
          end
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int o0, o1;
    set_trig(5'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst midi_tx", 32'(ln), 32'h3);
    chk("rst busy", 32'(if0.busy), 32'd0);
    chk("rst overflow", 32'(if0.overflow), 32'd0);
    chk("rst level", 32'(if0.fifo_level), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single snare, with first-start latency
    hit(5'b00010, 1'b1);
    lat = 1;
    while (ln[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    chk("latency rs0", 32'(ln[1]), 32'd0);
    wait_idle("t1");

    // kick: status dropped on the running-status port only
    hit(5'b00001, 1'b1);
    wait_idle("t2");

    // all five pads in one cycle
    o0 = ovf0;
    o1 = ovf1;
    hit(5'b11111, 1'b1);
    wait_idle("t3");
    chk("t3 ovf0", 32'(ovf0), 32'(o0));
    chk("t3 ovf1", 32'(ovf1), 32'(o1));

    // fill the FIFO while the line is busy
    hit(5'b10000, 1'b1);
    repeat (2) @(negedge clk);
    hit(5'b00001, 1'b1); repeat (2) @(negedge clk);
    hit(5'b00010, 1'b1); repeat (2) @(negedge clk);
    hit(5'b00100, 1'b1); repeat (2) @(negedge clk);
    hit(5'b01000, 1'b1); repeat (2) @(negedge clk);
    hit(5'b10000, 1'b1); repeat (2) @(negedge clk);
    hit(5'b00001, 1'b1); repeat (2) @(negedge clk);
    hit(5'b00010, 1'b1); repeat (2) @(negedge clk);
    hit(5'b00100, 1'b1); repeat (2) @(negedge clk);
    chk("t4 level0", 32'(if0.fifo_level), 32'd8);
    chk("t4 level1", 32'(if1.fifo_level), 32'd8);
    o0 = ovf0;
    o1 = ovf1;
    hit(5'b01000, 1'b1);
    repeat (2) @(negedge clk);
    chk("t4 hold level", 32'(if0.fifo_level), 32'd8);
    chk("t4 hold ovf", 32'(ovf0), 32'(o0));
    hit(5'b01000, 1'b0);
    repeat (2) @(negedge clk);
    chk("t4 ovf0", 32'(ovf0), 32'(o0 + 1));
    chk("t4 ovf1", 32'(ovf1), 32'(o1 + 1));
    wait_idle("t4");

    // reset in the middle of a zero data bit
    hit(5'b00100, 1'b1);
    repeat (43) @(negedge clk);
    chk("t5 pre line", 32'(ln), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5 async line", 32'(ln), 32'h3);
    chk("t5 level", 32'(if0.fifo_level), 32'd0);
    repeat (3) @(negedge clk);
    exp0.delete();
    exp1.delete();
    st0 = 1'b0;
    chk("t5 busy", 32'(if0.busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    hit(5'b00001, 1'b1);
    wait_idle("t5");

    // re-trigger on the cycle the pending bit is pushed
    o0 = ovf0;
    o1 = ovf1;
    hit(5'b00010, 1'b1);
    hit(5'b00010, 1'b1);
    wait_idle("t6");
    chk("t6 ovf0", 32'(ovf0), 32'(o0));
    chk("t6 ovf1", 32'(ovf1), 32'(o1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
